// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin arbiter sharing the single-port data memory between
// the load/store unit (port 0) and the DMA/loader (port 1), with range and alignment checks.
module data_memory_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_SIZE      = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m0_req,
    input  logic                     m0_we,
    input  logic                     m0_be,
    input  logic [ADDRESS_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0]    m0_wdata,
    output logic                     m0_gnt,
    output logic                     m0_rvalid,
    output logic                     m0_err,
    output logic [DATA_WIDTH-1:0]    m0_rdata,
    input  logic                     m1_req,
    input  logic                     m1_we,
    input  logic                     m1_be,
    input  logic [ADDRESS_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0]    m1_wdata,
    output logic                     m1_gnt,
    output logic                     m1_rvalid,
    output logic                     m1_err,
    output logic [DATA_WIDTH-1:0]    m1_rdata,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic                     mem_be,
    input  logic [DATA_WIDTH-1:0]    mem_read_data,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t                   state_q;
    logic                     last_q, we_q, err_q;
    logic                     win, take, sel_we, sel_be, sel_err;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata, rd_ext;

    // last_q doubles as the owner of the transaction in flight
    always_comb begin
        win       = (m0_req && m1_req) ? !last_q : m1_req;
        take      = rst && state_q == IDLE && (m0_req || m1_req);
        sel_we    = win ? m1_we : m0_we;
        sel_be    = win ? m1_be : m0_be;
        sel_addr  = win ? m1_addr : m0_addr;
        sel_wdata = win ? m1_wdata : m0_wdata;
        sel_err   = (sel_addr >> 2) >= ADDRESS_WIDTH'(MEM_SIZE) || (!sel_be && sel_addr[1:0] != 2'b00);
        rd_ext    = mem_be ? {{(DATA_WIDTH-8){1'b0}}, mem_read_data[7:0]} : mem_read_data;
    end

    assign m0_gnt = take && !win;
    assign m1_gnt = take && win;
    assign busy   = state_q != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            last_q         <= 1'b1;
            we_q           <= 1'b0;
            err_q          <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_we         <= 1'b0;
            mem_re         <= 1'b0;
            mem_be         <= 1'b0;
            m0_rvalid      <= 1'b0;
            m1_rvalid      <= 1'b0;
            m0_err         <= 1'b0;
            m1_err         <= 1'b0;
            m0_rdata       <= '0;
            m1_rdata       <= '0;
        end else begin
            case (state_q)
                IDLE: if (take) begin
                    state_q <= ISSUE;
                    last_q  <= win;
                    we_q    <= sel_we;
                    err_q   <= sel_err;
                    if (!sel_err) begin
                        mem_we         <= sel_we;
                        mem_re         <= !sel_we;
                        mem_be         <= sel_be;
                        mem_address    <= sel_addr;
                        mem_write_data <= sel_be ? {{(DATA_WIDTH-8){1'b0}}, sel_wdata[7:0]} : sel_wdata;
                    end
                end
                ISSUE: if (!we_q && !err_q) begin
                    state_q <= WAIT;
                end else begin
                    state_q   <= RESP;
                    mem_we    <= 1'b0;
                    mem_re    <= 1'b0;
                    m0_rvalid <= !last_q;
                    m1_rvalid <= last_q;
                    m0_err    <= !last_q && err_q;
                    m1_err    <= last_q && err_q;
                end
                WAIT: begin
                    state_q   <= RESP;
                    mem_re    <= 1'b0;
                    m0_rvalid <= !last_q;
                    m1_rvalid <= last_q;
                    m0_rdata  <= last_q ? m0_rdata : rd_ext;
                    m1_rdata  <= last_q ? rd_ext : m1_rdata;
                end
                RESP: begin
                    state_q   <= IDLE;
                    m0_rvalid <= 1'b0;
                    m1_rvalid <= 1'b0;
                    m0_err    <= 1'b0;
                    m1_err    <= 1'b0;
                end
            endcase
        end
    end
endmodule
